// File: rtl/wb_mem_arbiter.sv
// Two-master Wishbone arbiter for the shared image-memory port.
// Round-robin on cycle boundaries, with a watchdog that turns a hung slave into err.
module wb_mem_arbiter #(
    parameter int AW      = 22,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    input  logic          m0_we_i,
    input  logic [AW-1:0] m0_adr_i,
    input  logic [DW-1:0] m0_dat_i,
    output logic [DW-1:0] m0_dat_o,
    output logic          m0_ack_o,
    output logic          m0_err_o,
    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    input  logic          m1_we_i,
    input  logic [AW-1:0] m1_adr_i,
    input  logic [DW-1:0] m1_dat_i,
    output logic [DW-1:0] m1_dat_o,
    output logic          m1_ack_o,
    output logic          m1_err_o,
    output logic          s_cyc_o,
    output logic          s_stb_o,
    output logic          s_we_o,
    output logic [AW-1:0] s_adr_o,
    output logic [DW-1:0] s_dat_o,
    input  logic [DW-1:0] s_dat_i,
    input  logic          s_ack_i,
    output logic [1:0]    gnt_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_last;
    logic          w_last_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_stb;
    logic          w_fire;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_stb       = 1'b0;
        s_cyc_o     = 1'b0;
        s_we_o      = 1'b0;
        s_adr_o     = '0;
        s_dat_o     = '0;
        case (r_state)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i)
                    w_state_nxt = r_last ? GNT0 : GNT1;
                else if (m0_cyc_i)
                    w_state_nxt = GNT0;
                else if (m1_cyc_i)
                    w_state_nxt = GNT1;
            end
            GNT0: begin
                s_cyc_o = m0_cyc_i;
                w_stb   = m0_stb_i;
                s_we_o  = m0_we_i;
                s_adr_o = m0_adr_i;
                s_dat_o = m0_dat_i;
                if (!m0_cyc_i)
                    w_state_nxt = m1_cyc_i ? GNT1 : IDLE;
            end
            GNT1: begin
                s_cyc_o = m1_cyc_i;
                w_stb   = m1_stb_i;
                s_we_o  = m1_we_i;
                s_adr_o = m1_adr_i;
                s_dat_o = m1_dat_i;
                if (!m1_cyc_i)
                    w_state_nxt = m0_cyc_i ? GNT0 : IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase

        if (w_state_nxt == GNT0)
            w_last_nxt = 1'b0;
        else if (w_state_nxt == GNT1)
            w_last_nxt = 1'b1;

        // A late ack in the timeout cycle still completes the access
        w_fire  = w_stb && !s_ack_i && (r_cnt == CW'(TIMEOUT));
        s_stb_o = w_stb && !w_fire;

        if ((w_state_nxt != r_state) || !w_stb || s_ack_i || w_fire)
            w_cnt_nxt = '0;
        else
            w_cnt_nxt = r_cnt + CW'(1);

        m0_ack_o = s_ack_i && (r_state == GNT0) && m0_stb_i;
        m1_ack_o = s_ack_i && (r_state == GNT1) && m1_stb_i;
        m0_err_o = w_fire && (r_state == GNT0);
        m1_err_o = w_fire && (r_state == GNT1);
        gnt_o    = {r_state == GNT1, r_state == GNT0};
        m0_dat_o = s_dat_i;
        m1_dat_o = s_dat_i;
    end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed bench for wb_mem_arbiter: vector table for arbitration and
// handoff, hand sequences for back-to-back reads, watchdog and reset.
module tb_wb_mem_arbiter;

    localparam int AW = 22;
    localparam int DW = 32;
    localparam logic [AW-1:0] A0 = 22'h000100;
    localparam logic [AW-1:0] A1 = 22'h000200;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_cyc, m0_stb, m0_we;
    logic [AW-1:0] m0_adr;
    logic [DW-1:0] m0_dat_w, m0_dat_r;
    logic          m0_ack, m0_err;
    logic          m1_cyc, m1_stb, m1_we;
    logic [AW-1:0] m1_adr;
    logic [DW-1:0] m1_dat_w, m1_dat_r;
    logic          m1_ack, m1_err;
    logic          s_cyc, s_stb, s_we;
    logic [AW-1:0] s_adr;
    logic [DW-1:0] s_dat_w, s_dat_r;
    logic          s_ack;
    logic [1:0]    gnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(8)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_dat_w), .m0_dat_o(m0_dat_r),
        .m0_ack_o(m0_ack), .m0_err_o(m0_err),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_dat_w), .m1_dat_o(m1_dat_r),
        .m1_ack_o(m1_ack), .m1_err_o(m1_err),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we),
        .s_adr_o(s_adr), .s_dat_o(s_dat_w), .s_dat_i(s_dat_r),
        .s_ack_i(s_ack), .gnt_o(gnt)
    );

    typedef struct packed {
        logic          rst, c0, s0, w0, c1, s1, w1, ack;
        logic [1:0]    gnt;
        logic          scyc, sstb;
        logic [AW-1:0] adr;
        logic          a0, a1, e0, e1;
    } vec_t;

    vec_t tbl[21];

    function automatic vec_t mk(input logic [7:0] in, input logic [1:0] g,
                                input logic sc, input logic ss,
                                input logic [AW-1:0] ad, input logic [3:0] ae);
        vec_t v;
        {v.rst, v.c0, v.s0, v.w0, v.c1, v.s1, v.w1, v.ack} = in;
        v.gnt = g; v.scyc = sc; v.sstb = ss; v.adr = ad;
        {v.a0, v.a1, v.e0, v.e1} = ae;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] in);
        {rst, m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we, s_ack} = in;
    endtask

    // two idle cycles to land back in IDLE
    task automatic idle2(input string nm);
        #1 drive(8'b0);
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk(nm, 64'(gnt), 64'(2'b00));
        @(posedge clk);
    endtask

    int reads, m0cnt, errs, cycles, wcnt;
    bit dat_seen;

    initial begin
        tbl[0]  = mk(8'b1111_1100, 2'b00, 0, 0, '0, 4'b0000);
        tbl[1]  = mk(8'b0111_1100, 2'b00, 0, 0, '0, 4'b0000);
        tbl[2]  = mk(8'b0111_1101, 2'b01, 1, 1, A0, 4'b1000);
        tbl[3]  = mk(8'b0000_1100, 2'b01, 0, 0, A0, 4'b0000);
        tbl[4]  = mk(8'b0111_1101, 2'b10, 1, 1, A1, 4'b0100);
        tbl[5]  = mk(8'b0111_0000, 2'b10, 0, 0, A1, 4'b0000);
        tbl[6]  = mk(8'b0111_1101, 2'b01, 1, 1, A0, 4'b1000);
        tbl[7]  = mk(8'b0111_1100, 2'b01, 1, 1, A0, 4'b0000);
        tbl[8]  = mk(8'b0111_1101, 2'b01, 1, 1, A0, 4'b1000);
        tbl[9]  = mk(8'b0111_1101, 2'b01, 1, 1, A0, 4'b1000);
        tbl[10] = mk(8'b0111_1101, 2'b01, 1, 1, A0, 4'b1000);
        tbl[11] = mk(8'b0000_1100, 2'b01, 0, 0, A0, 4'b0000);
        tbl[12] = mk(8'b0000_1101, 2'b10, 1, 1, A1, 4'b0100);
        tbl[13] = mk(8'b0000_0000, 2'b10, 0, 0, A1, 4'b0000);
        tbl[14] = mk(8'b0000_0000, 2'b00, 0, 0, '0, 4'b0000);
        tbl[15] = mk(8'b0100_1000, 2'b00, 0, 0, '0, 4'b0000);
        tbl[16] = mk(8'b0110_1000, 2'b01, 1, 1, A0, 4'b0000);
        tbl[17] = mk(8'b0000_1000, 2'b01, 0, 0, A0, 4'b0000);
        tbl[18] = mk(8'b0000_1100, 2'b10, 1, 1, A1, 4'b0000);
        tbl[19] = mk(8'b0000_0000, 2'b10, 0, 0, A1, 4'b0000);
        tbl[20] = mk(8'b0000_0000, 2'b00, 0, 0, '0, 4'b0000);

        m0_adr = A0; m0_dat_w = 32'hDEADBEEF;
        m1_adr = A1; m1_dat_w = 32'h12345678;
        s_dat_r = 32'hC0FFEE01;
        drive(8'b1111_1100);
        @(posedge clk);

        for (int i = 0; i < 21; i++) begin
            #1 drive({tbl[i].rst, tbl[i].c0, tbl[i].s0, tbl[i].w0,
                      tbl[i].c1, tbl[i].s1, tbl[i].w1, tbl[i].ack});
            @(negedge clk);
            chk($sformatf("vec%0d", i),
                64'({gnt, s_cyc, s_stb, s_adr, m0_ack, m1_ack, m0_err, m1_err}),
                64'({tbl[i].gnt, tbl[i].scyc, tbl[i].sstb, tbl[i].adr,
                     tbl[i].a0, tbl[i].a1, tbl[i].e0, tbl[i].e1}));
            if (i == 2)
                chk("wr_data", 64'({s_we, s_dat_w}), 64'({1'b1, 32'hDEADBEEF}));
            @(posedge clk);
        end

        // ten reads by master 1, slave acks after 3 wait cycles
        reads = 0; m0cnt = 0; errs = 0; cycles = 0; wcnt = 0; dat_seen = 0;
        #1 drive(8'b0000_1100);
        for (int k = 0; k < 80 && reads < 10; k++) begin
            if (k != 0) #1;
            s_ack = s_stb && (wcnt == 3);
            @(negedge clk);
            if (m1_ack) begin
                reads++;
                if (!dat_seen) chk("rd_data", 64'(m1_dat_r), 64'(32'hC0FFEE01));
                dat_seen = 1;
            end
            if (m0_ack) m0cnt++;
            if (m0_err || m1_err) errs++;
            wcnt = (s_stb && !s_ack) ? wcnt + 1 : 0;
            cycles++;
            @(posedge clk);
        end
        chk("rd_acks", 64'(reads), 64'(10));
        chk("rd_m0_acks", 64'(m0cnt), 64'(0));
        chk("rd_errs", 64'(errs), 64'(0));
        chk("rd_cycles", 64'(cycles), 64'(41));
        idle2("rd_idle");

        // watchdog with slave that never answers
        #1 drive(8'b0111_0000);
        @(negedge clk);
        @(posedge clk);
        for (int k = 1; k <= 18; k++) begin
            #1;
            @(negedge clk);
            chk($sformatf("wdog%0d", k), 64'({s_stb, m0_err, m1_err}),
                64'({(k != 9 && k != 18), (k == 9 || k == 18), 1'b0}));
            @(posedge clk);
        end
        idle2("wdog_idle");

        // ack lands exactly on the timeout cycle
        #1 drive(8'b0110_0000);
        @(negedge clk);
        @(posedge clk);
        for (int k = 1; k <= 9; k++) begin
            #1 s_ack = (k == 9);
            @(negedge clk);
            if (k >= 8)
                chk($sformatf("coll%0d", k), 64'({s_stb, m0_ack, m0_err}),
                    64'({1'b1, (k == 9), 1'b0}));
            @(posedge clk);
        end
        idle2("coll_idle");

        // reset in the middle of a master 1 read
        #1 drive(8'b0000_1100);
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("mrst_gnt1", 64'(gnt), 64'(2'b10));
        @(posedge clk);
        #1 drive(8'b1000_1100);
        @(negedge clk);
        @(posedge clk);
        #1 drive(8'b0110_1101);
        @(negedge clk);
        chk("mrst_after", 64'({gnt, s_cyc, m0_ack, m1_ack}), 64'({2'b00, 3'b000}));
        @(posedge clk);
        #1 s_ack = 1'b0;
        @(negedge clk);
        chk("mrst_last", 64'(gnt), 64'(2'b01));
        @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
